// File: rtl/mux8_sync.sv
// mux8_sync: 8-to-1 lane selector.
// Y is the combinational selected lane. y_q/out_valid form a registered copy
// with synchronous reset, hold and capture qualification.
// Optional macro MUX8_PARITY_EN adds y_par (parity of Y) and y_q_par
// (parity of the captured sample).
module mux8_sync #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [8*WIDTH-1:0] D,
  input  logic [2:0]         sel,
  input  logic               in_valid,
  input  logic               hold,
  output logic [WIDTH-1:0]   Y,
  output logic [WIDTH-1:0]   y_q,
  output logic               out_valid
`ifdef MUX8_PARITY_EN
  ,
  output logic               y_par,
  output logic               y_q_par
`endif
);

  // Unpack the flat lane bus so the select is a plain array index.
  logic [WIDTH-1:0] lanes [8];

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      assign lanes[gi] = D[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // All eight codes map to a lane, so the selection is complete and latch-free.
  assign Y = lanes[sel];

  logic [WIDTH-1:0] y_q_reg;
  logic             out_valid_reg;

  // Registered path: reset beats hold, hold beats capture, idle drops valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else if (!hold) begin
      if (in_valid) begin
        y_q_reg       <= Y;
        out_valid_reg <= 1'b1;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign y_q       = y_q_reg;
  assign out_valid = out_valid_reg;

`ifdef MUX8_PARITY_EN
  logic y_q_par_reg;

  assign y_par = ^Y;

  // Parity of the captured sample follows the same reset/hold/capture rules.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q_par_reg <= 1'b0;
    end else if (!hold && in_valid) begin
      y_q_par_reg <= ^Y;
    end
  end

  assign y_q_par = y_q_par_reg;
`endif

endmodule

// File: tb/tb_mux8_sync.sv
// Testbench for mux8_sync: a WIDTH=1 and a WIDTH=8 instance share control
// inputs. The driver pushes per-cycle expectations of the registered path
// into a queue; a monitor pops and compares one entry after each clock edge.
module tb_mux8_sync;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        hold = 1'b0;
  logic [2:0]  sel = 3'd0;
  logic [7:0]  d1 = 8'h00;
  logic [63:0] d8 = 64'h0;

  logic [0:0]  y1, yq1;
  logic        ov1;
  logic [7:0]  y8, yq8;
  logic        ov8;
`ifdef MUX8_PARITY_EN
  logic        ypar1, yqpar1, ypar8, yqpar8;
`endif

  mux8_sync #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .D(d1), .sel(sel), .in_valid(in_valid), .hold(hold),
    .Y(y1), .y_q(yq1), .out_valid(ov1)
`ifdef MUX8_PARITY_EN
    , .y_par(ypar1), .y_q_par(yqpar1)
`endif
  );

  mux8_sync #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .D(d8), .sel(sel), .in_valid(in_valid), .hold(hold),
    .Y(y8), .y_q(yq8), .out_valid(ov8)
`ifdef MUX8_PARITY_EN
    , .y_par(ypar8), .y_q_par(yqpar8)
`endif
  );

  typedef struct packed {
    logic       v;
    logic [0:0] y1;
    logic [7:0] y8;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  // Reference state of the registered path
  logic       m_v = 1'b0;
  logic [0:0] m_y1 = 1'b0;
  logic [7:0] m_y8 = 8'h00;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [0:0] ref_lane1(input logic [7:0] d, input int s);
    return 1'((d >> s) & 8'h01);
  endfunction

  function automatic logic [7:0] ref_lane8(input logic [63:0] d, input int s);
    return 8'((d >> (s * 8)) & 64'hFF);
  endfunction

  function automatic logic ref_par(input logic [7:0] v);
    return 1'($countones(v) % 2);
  endfunction

  // Apply one cycle of stimulus, advance the model, check Y combinationally.
  task automatic step(input logic r, input logic iv, input logic h,
                      input logic [2:0] s, input logic [7:0] a1, input logic [63:0] a8);
    exp_t e;
    @(negedge clk);
    rst = r; in_valid = iv; hold = h; sel = s; d1 = a1; d8 = a8;
    if (r) begin
      m_v = 1'b0; m_y1 = 1'b0; m_y8 = 8'h00;
    end else if (!h) begin
      if (iv) begin
        m_v = 1'b1; m_y1 = ref_lane1(a1, int'(s)); m_y8 = ref_lane8(a8, int'(s));
      end else begin
        m_v = 1'b0;
      end
    end
    e.v = m_v; e.y1 = m_y1; e.y8 = m_y8;
    sb.push_back(e);
    #1;
    $display("step rst=%0b iv=%0b hold=%0b sel=%0d d1=%02h d8=%016h Y1=%0b Y8=%02h",
             r, iv, h, s, a1, a8, y1, y8);
    check("Y_w1", 64'(y1), 64'(ref_lane1(a1, int'(s))));
    check("Y_w8", 64'(y8), 64'(ref_lane8(a8, int'(s))));
`ifdef MUX8_PARITY_EN
    check("y_par_w8", 64'(ypar8), 64'(ref_par(ref_lane8(a8, int'(s)))));
    check("y_par_w1", 64'(ypar1), 64'(ref_lane1(a1, int'(s))));
`endif
  endtask

  // Monitor: after every edge that had stimulus, compare registered outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("out_valid_w1", 64'(ov1), 64'(e.v));
        check("out_valid_w8", 64'(ov8), 64'(e.v));
        check("y_q_w1", 64'(yq1), 64'(e.y1));
        check("y_q_w8", 64'(yq8), 64'(e.y8));
`ifdef MUX8_PARITY_EN
        check("y_q_par_w8", 64'(yqpar8), 64'(ref_par(e.y8)));
        check("y_q_par_w1", 64'(yqpar1), 64'(e.y1));
`endif
      end
    end
  end

  localparam logic [7:0]  PAT  = 8'b10110101;
  localparam logic [63:0] RAMP = 64'h0706050403020100;

  initial begin
    // Reset for two cycles with capture requested; Y must still select.
    step(1, 1, 0, 3'd0, 8'hFF, RAMP);
    step(1, 1, 0, 3'd0, 8'hFF, RAMP);
    // Walk sel over the pattern with the registered path idle.
    for (int s = 0; s < 8; s++) step(0, 0, 0, 3'(s), PAT, RAMP);
    // Back-to-back captures: sel=2 then sel=3.
    step(0, 1, 0, 3'd2, PAT, RAMP);
    step(0, 1, 0, 3'd3, PAT, RAMP);
    // Capture a 1, hold for three cycles, then release onto sel=1.
    step(0, 1, 0, 3'd2, PAT, RAMP);
    for (int k = 0; k < 3; k++) step(0, 1, 1, 3'd1, PAT, RAMP);
    step(0, 1, 0, 3'd1, PAT, RAMP);
    // Idle cycle drops valid, keeps data.
    step(0, 0, 0, 3'd2, PAT, RAMP);
    // Wide lanes: sel=5 then sel=7.
    step(0, 1, 0, 3'd5, PAT, RAMP);
    step(0, 1, 0, 3'd7, PAT, RAMP);
    // Reset mid-stream, then capture on the first released edge.
    step(1, 1, 1, 3'd7, PAT, RAMP);
    step(0, 1, 0, 3'd6, PAT, RAMP);
    // Hold while invalid keeps valid high.
    step(0, 0, 1, 3'd0, PAT, RAMP);
    // Randomised traffic.
    for (int n = 0; n < 300; n++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 4) == 0), 3'($urandom_range(0, 7)),
           8'($urandom), {$urandom, $urandom});
    end
    step(0, 0, 0, 3'd0, 8'h00, 64'h0);
    @(posedge clk);
    @(posedge clk);
    #2;
    check("scoreboard_drain", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux8_sync.md
Name: mux8_sync

Overview:
- 8-to-1 selector. Picks one of eight data lanes by a 3-bit select.
- Y is a purely combinational output: it is the selected lane, with no clock involved.
- A registered copy of the selected lane, y_q, comes with a valid flag, for pipelined consumers.
- Used as a leaf datapath selector in combinational-logic exercises and in larger datapaths.

Parameters:
- WIDTH, default 1: bit width of each data lane and of both outputs. Legal range 1..64.

Ports:
- clk  input  1  system clock; all registers update on the rising edge.
- rst  input  1  synchronous, active-high reset.
- D  input  8*WIDTH  packed data lanes; lane i occupies D[i*WIDTH +: WIDTH]. Lane 0 is the LSBs.
- sel  input  3  lane select, unsigned 0..7.
- in_valid  input  1  qualifies D/sel for capture into the registered path.
- hold  input  1  freezes the registered path while high.
- Y  output  WIDTH  combinational selected lane.
- y_q  output  WIDTH  registered selected lane.
- out_valid  output  1  high when y_q holds a captured sample.

Behaviour:
- Y = D[sel*WIDTH +: WIDTH] at all times, combinationally.
  - Y is independent of clk, rst, in_valid and hold.
  - Y is valid in and out of reset.
  - Zero-cycle latency: a change in sel or D is reflected in Y within the same delta/propagation.
- With WIDTH=1, Y = D[sel].
- All eight sel codes are legal; there is no default/X output.
  - If sel contains X/Z in simulation, Y may be X. The RTL must not add latches.
- Registered path, evaluated in priority order at each rising clk:
  1. rst=1: y_q <= 0, out_valid <= 0. Reset wins over hold and in_valid.
  2. else hold=1: y_q and out_valid keep their values, regardless of in_valid.
  3. else in_valid=1: y_q <= D[sel*WIDTH +: WIDTH], out_valid <= 1.
  4. else: y_q keeps its value, out_valid <= 0.
- Latency of the registered path: one clock from capture edge to y_q/out_valid.
- Back-to-back in_valid with changing sel: y_q tracks each sample on consecutive cycles.
- Reset asserted mid-stream: on the reset edge, out_valid drops and y_q clears. The first capture after reset release occurs on the first edge with rst=0 and in_valid=1.
- Reset values: y_q=0, out_valid=0. Y has no reset value (combinational).

Optional Feature:
- Macro MUX8_PARITY_EN.
- When defined:
  - Extra output y_par (1 bit, combinational) = XOR-reduction of Y.
  - Extra output y_q_par (1 bit, registered) = XOR-reduction of the value captured into y_q.
  - y_q_par follows the same reset (0), hold and capture rules as y_q.
- When undefined: neither port exists. All other behaviour is identical.

Test Plan:
- WIDTH=1, D=8'b10110101, sel stepped 0..7 at 20 ns intervals -> Y = 1,0,1,0,1,1,0,1 respectively. Each value is settled within the interval.
- rst=1 for 2 cycles with in_valid=1, sel=0, D=8'hFF -> y_q=0 and out_valid=0 after each reset edge. Y=1 throughout.
- rst=0, in_valid=1, D=8'b10110101, sel=2 then sel=3 on consecutive edges -> y_q=1 then 0, one cycle after each capture edge. out_valid=1 for both cycles.
- After y_q=1 captured, hold=1 with in_valid=1 and sel=1 for 3 cycles -> y_q stays 1, out_valid stays 1. On the first edge after hold drops (in_valid=1, sel=1) -> y_q=0.
- in_valid=0 for one cycle after a capture -> out_valid=0 and y_q unchanged.
- WIDTH=8, D=64'h0706050403020100, sel=5 -> Y=8'h05. With in_valid=1, y_q=8'h05 after one edge. If MUX8_PARITY_EN is defined, y_par=0 and y_q_par=0. With sel=7, Y=8'h07 and y_par=1.
